// File: rtl/serial_parity_checker.sv
// Serial frame receiver: WIDTH data bits (LSB first) then one parity bit.
// Rebuilds the data word, flags parity mismatch and counts bad frames (saturating).
module serial_parity_checker #(
    parameter int WIDTH = 8,
    parameter bit ODD   = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] data,
    output logic             parity_err,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] err_count
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             acc_q, acc_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             perr_q, perr_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic             err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ecnt_d  = ecnt_q;
        done_d  = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE doubles as a start slot so frames can run back to back
                if (start) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    shreg_d = '0;
                    acc_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (din_valid) begin
                    shreg_d = {din, shreg_q[WIDTH-1:1]};
                    acc_d   = acc_q ^ din;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1))
                        state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (din_valid) begin
                    err     = acc_q ^ din ^ ODD;
                    data_d  = shreg_q;
                    perr_d  = err;
                    if (err && (ecnt_q != '1))
                        ecnt_d = ecnt_q + CNT_W'(1);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_DATA) || (state_d == S_PARITY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign data       = data_q;
    assign parity_err = perr_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign err_count  = ecnt_q;
endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Receiving end of the team's parity scheme: accepts a serial frame of WIDTH data bits followed by one parity bit, reassembles the data word and flags a parity mismatch. It sits downstream of a serial link whose transmitter appends a parity bit of the same sense (even or odd). It also keeps a saturating count of bad frames for status readout.

Parameters:
WIDTH, 8, number of data bits per frame (legal range 2..32)
ODD, 0, parity sense: 0 = even parity (data plus parity has an even number of ones), 1 = odd parity
CNT_W, 8, width of the error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  frame start strobe; accepted only in IDLE or DONE
din  input  1  serial bit, LSB first, parity bit last
din_valid  input  1  din is valid this cycle; bits with din_valid=0 are skipped (gaps allowed)
data  output  WIDTH  last completed frame's data word
parity_err  output  1  parity result of last completed frame (1 = mismatch)
done  output  1  one-cycle pulse: data/parity_err updated
busy  output  1  high in DATA and PARITY states
err_count  output  CNT_W  saturating count of frames with parity_err=1

Behaviour:
- Reset (async, rst=1): state=IDLE, data=0, parity_err=0, done=0, busy=0, err_count=0, bit counter=0, shift register=0, running parity=0. Takes effect immediately, including mid-frame; the partial frame is discarded with no done pulse.
- FSM states: IDLE, DATA, PARITY, DONE. All outputs are registered.
- IDLE: busy=0. start=1 -> DATA; clear the bit counter, shift register and running parity. Any din/din_valid in the start cycle is ignored; the first data bit is sampled on a later cycle.
- DATA: busy=1. On each cycle with din_valid=1, shift din in from the MSB end (shreg <= {din, shreg[WIDTH-1:1]}), update running parity (acc ^= din), and increment the counter. When the WIDTH-th bit is accepted (counter==WIDTH-1 with din_valid), go to PARITY. start is ignored in this state.
- PARITY: busy=1. On din_valid=1, compute err = acc ^ din ^ ODD, then go to DONE. Cycles with din_valid=0 wait. start is ignored.
- DONE: held for exactly one cycle. done=1, busy=0. data=shreg (the first received bit lands in data[0]). parity_err=err. If err=1 and err_count < 2^CNT_W-1, increment err_count; at the maximum it holds (saturates).
  - start=1 in DONE: go directly to DATA and clear working registers. This supports back-to-back frames with no idle cycle.
  - otherwise: go to IDLE.
- Latency: done is asserted on the cycle after the parity bit is sampled. The minimum frame is start cycle + WIDTH + 1 bit cycles + 1 DONE cycle.
- data and parity_err hold their values until the next DONE cycle; they are not cleared by start.
- din_valid outside DATA/PARITY is ignored.
- Non-start inputs in IDLE have no effect.

Test Plan:
- Reset, then start. Send WIDTH=8, ODD=0 bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), then parity 0 -> done pulse one cycle after the parity bit, data=0xA5, parity_err=0, err_count=0.
- Same frame with parity bit 1 -> data=0xA5, parity_err=1, err_count=1. busy is high from the cycle after start through the parity cycle.
- ODD=1 instance: send 0x07 with parity 0 -> parity_err=0. Send 0x07 with parity 1 -> parity_err=1.
- Same 0xA5/parity-0 frame with din_valid dropped for 3 cycles after bit 3 and for 2 cycles before the parity bit -> identical result; done is delayed by exactly 5 cycles.
- Assert rst after the 4th data bit, then send a full good frame 0x3C -> no done pulse for the aborted frame; err_count=0; next frame yields data=0x3C, parity_err=0.
- Drive 300 consecutive bad frames back-to-back, with start asserted in each DONE cycle -> err_count saturates at 255, no idle cycle between frames, exactly 300 done pulses.
